down_counter_timer: RTL and testbench

DOWN_COUNTER_TIMER -- requirements
Module: down_counter_timer

---
 rtl/down_counter_timer_pkg.sv | 18 +
 rtl/down_counter_timer_rate_divider.sv | 41 ++++
 rtl/down_counter_timer.sv | 87 ++++++++
 tb/tb_down_counter_timer.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down-counter timer: FSM state encodings,
// the default divide ratio and the divider width helper.
package down_counter_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned DIV_DEFAULT = 50_000_000;

  // Divider width is clog2(div), never narrower than one bit.
  function automatic int unsigned div_width(input int unsigned div);
    return ($clog2(div) < 1) ? 1 : int'($clog2(div));
  endfunction

endpackage

// File: rtl/down_counter_timer_rate_divider.sv
// Count-step generator: counts DIV enabled cycles and flags a tick on the
// last one. The zero-detect is held in a flop so tick has no adder in its path.
module rate_divider
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned W = div_width(DIV);
  localparam logic [W-1:0] RELOAD = W'(DIV - 1);
  localparam logic RELOAD_ZERO = (DIV == 1);

  logic [W-1:0] count;
  logic         zero;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= RELOAD;
      zero  <= RELOAD_ZERO;
    end else if (enable) begin
      if (zero) begin
        count <= RELOAD;
        zero  <= RELOAD_ZERO;
      end else begin
        count <= count - W'(1);
        zero  <= (count == W'(1));
      end
    end
  end

  assign tick = enable && zero;

endmodule

// File: rtl/down_counter_timer.sv
// Loadable 4-bit countdown timer: IDLE -> RUN -> DONE, one count step every
// DIV enabled cycles, with a single-cycle done pulse on reaching zero.
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int unsigned DIV = DIV_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] freshdata,
  input  logic       start,
  input  logic       enable,
  output logic [3:0] q,
  output logic       running,
  output logic       expired,
  output logic       done
);

  state_t     state, state_next;
  logic [3:0] q_next;
  logic       done_next;
  logic       clear;
  logic       div_enable;
  logic       tick;

  assign div_enable = (state == RUN) && enable;

  rate_divider #(.DIV(DIV)) u_div (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (div_enable),
    .tick   (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      q     <= 4'd0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      q     <= q_next;
      done  <= done_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    q_next     = q;
    done_next  = 1'b0;
    clear      = 1'b0;
    if (load) begin
      q_next     = freshdata;
      state_next = IDLE;
      clear      = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && (q != 4'd0)) begin
            state_next = RUN;
            clear      = 1'b1;
          end
        end
        RUN: begin
          // q is never 0 in RUN; the guard keeps the count from wrapping.
          if (tick && (q != 4'd0)) begin
            q_next = q - 4'd1;
            if (q == 4'd1) begin
              state_next = DONE;
              done_next  = 1'b1;
            end
          end
        end
        DONE:    ;
        default: state_next = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign expired = (state == DONE);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: DIV=4 instance for the main
// scenarios and a DIV=1 instance for the every-cycle decrement case.
module tb_down_counter_timer;

  logic       clock = 1'b0;
  logic       reset, load, start, enable;
  logic [3:0] freshdata;
  logic [3:0] q;
  logic       running, expired, done;

  logic       b_reset, b_load, b_start, b_enable;
  logic [3:0] b_freshdata;
  logic [3:0] b_q;
  logic       b_running, b_expired, b_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  down_counter_timer #(.DIV(4)) u_dut (
    .clock(clock), .reset(reset), .load(load), .freshdata(freshdata),
    .start(start), .enable(enable), .q(q), .running(running),
    .expired(expired), .done(done)
  );

  down_counter_timer #(.DIV(1)) u_dut1 (
    .clock(clock), .reset(b_reset), .load(b_load), .freshdata(b_freshdata),
    .start(b_start), .enable(b_enable), .q(b_q), .running(b_running),
    .expired(b_expired), .done(b_done)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; start = 1'b0; enable = 1'b0; freshdata = 4'd0;
    b_reset = 1'b1; b_load = 1'b0; b_start = 1'b0; b_enable = 1'b1; b_freshdata = 4'd0;
    step();
    check("rst_q", q, 0);
    check("rst_running", running, 0);
    check("rst_expired", expired, 0);
    check("rst_done", done, 0);
    reset = 1'b0; b_reset = 1'b0;

    // Full countdown from 3: steps every 4 cycles, done 12 cycles after start.
    load = 1'b1; freshdata = 4'd3; step();
    check("ld3_q", q, 3);
    load = 1'b0; start = 1'b1; enable = 1'b1; step();
    start = 1'b0;
    check("run_entry", running, 1);
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("cd_q_%0d", k), q, 3 - k / 4);
      check($sformatf("cd_done_%0d", k), done, (k == 12) ? 1 : 0);
    end
    check("cd_expired", expired, 1);
    check("cd_running", running, 0);
    step();
    check("done_one_cycle", done, 0);
    check("done_hold_exp", expired, 1);

    // start in DONE is ignored; load leaves DONE.
    start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("done_start_exp", expired, 1);
      check("done_start_q", q, 0);
      check("done_start_pulse", done, 0);
    end
    start = 1'b0; load = 1'b1; freshdata = 4'd7; step();
    load = 1'b0;
    check("done_ld7_q", q, 7);
    check("done_ld7_exp", expired, 0);
    check("done_ld7_run", running, 0);

    // Pause mid-RUN at q=2 with the divider two cycles from a tick.
    load = 1'b1; freshdata = 4'd3; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0;
    repeat (6) step();
    check("pause_pre_q", q, 2);
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      check("pause_q", q, 2);
      check("pause_running", running, 1);
    end
    enable = 1'b1;
    step(); check("resume1_q", q, 2);
    step(); check("resume2_q", q, 1);
    repeat (3) step();
    check("resume5_q", q, 1);
    check("resume5_done", done, 0);
    step();
    check("resume6_q", q, 0);
    check("resume6_done", done, 1);

    // Load coinciding with the tick at q=4 wins; no done pulse.
    load = 1'b1; freshdata = 4'd5; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0;
    repeat (7) step();
    check("ldtick_pre_q", q, 4);
    load = 1'b1; freshdata = 4'd9; step();
    load = 1'b0;
    check("ldtick_q", q, 9);
    check("ldtick_running", running, 0);
    check("ldtick_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("ldtick_after_done", done, 0);
      check("ldtick_after_q", q, 9);
    end

    // start with q==0 stays in IDLE.
    load = 1'b1; freshdata = 4'd0; step();
    load = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("zero_running", running, 0);
      check("zero_expired", expired, 0);
      check("zero_done", done, 0);
    end
    start = 1'b0;

    // Reset just before the final tick aborts with no done pulse.
    load = 1'b1; freshdata = 4'd1; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0;
    repeat (3) step();
    check("abort_pre_q", q, 1);
    check("abort_pre_run", running, 1);
    reset = 1'b1; step();
    check("abort_q", q, 0);
    check("abort_running", running, 0);
    check("abort_expired", expired, 0);
    check("abort_done", done, 0);
    reset = 1'b0; step();
    check("abort_after_done", done, 0);

    // DIV=1: decrement every enabled cycle, done 2 cycles after start.
    b_load = 1'b1; b_freshdata = 4'd2; step();
    b_load = 1'b0; b_start = 1'b1; step();
    b_start = 1'b0;
    check("d1_entry", b_running, 1);
    step();
    check("d1_q1", b_q, 1);
    check("d1_done1", b_done, 0);
    step();
    check("d1_q2", b_q, 0);
    check("d1_done2", b_done, 1);
    check("d1_exp2", b_expired, 1);
    step();
    check("d1_done3", b_done, 0);
    check("d1_q3", b_q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
